// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: state encoding, default width,
// divide-by-zero constants and the iteration-counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_FIX  = 2'd2,
    S_END  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_DATA_W = 32;

  // Divide by zero: every quotient bit is set; the remainder echoes the dividend.
  localparam logic DIV0_QUOT_BIT = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: trial-subtract the divisor from the
// shifted partial remainder and keep the difference only when it does not borrow.
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W:0]   r_shift,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] r_next,
  output logic              q_bit
);

  logic [DATA_W-1:0] diff;

  // R' < 2*D, so whenever the subtraction succeeds the difference fits in DATA_W bits.
  assign q_bit  = (r_shift >= {1'b0, d});
  assign diff   = r_shift[DATA_W-1:0] - d;
  assign r_next = q_bit ? diff : r_shift[DATA_W-1:0];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle radix-2 restoring divider with in_valid/stall/out_valid handshake.
// Define DIV_SIGNED_EN to add the div_signed port and the S_FIX sign-correction state.
module restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic              div_signed,
`endif
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              out_valid,
  output logic              stall
);

  localparam int unsigned CNT_W = cnt_width(DATA_W);

  state_t            state, state_next;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] q_work;
  logic [DATA_W-1:0] r_work;
  logic [DATA_W-1:0] d_work;
  logic [DATA_W:0]   r_shift;
  logic [DATA_W-1:0] r_next;
  logic [DATA_W-1:0] q_shifted;
  logic              q_bit;
  logic              last_step;
  logic              div_zero;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

`ifdef DIV_SIGNED_EN
  logic a_neg, b_neg;
  logic q_neg, r_neg;

  // Iterate on magnitudes; signs are reapplied in S_FIX.
  always_comb begin
    a_neg = div_signed & dividend[DATA_W-1];
    b_neg = div_signed & divisor[DATA_W-1];
    a_mag = a_neg ? (~dividend + DATA_W'(1)) : dividend;
    b_mag = b_neg ? (~divisor + DATA_W'(1)) : divisor;
  end
`else
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
  end
`endif

  assign div_zero  = (divisor == '0);
  assign last_step = (count == CNT_W'(DATA_W - 1));
  assign r_shift   = {r_work, q_work[DATA_W-1]};
  assign q_shifted = {q_work[DATA_W-2:0], q_bit};

  div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .r_shift (r_shift),
    .d       (d_work),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          stall      = 1'b1;
          state_next = div_zero ? S_END : S_OP;
        end
      end
      S_OP: begin
        stall = 1'b1;
        if (last_step) begin
`ifdef DIV_SIGNED_EN
          state_next = S_FIX;
`else
          state_next = S_END;
`endif
        end
      end
      S_FIX: begin
        stall      = 1'b1;
        state_next = S_END;
      end
      S_END: begin
        out_valid  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Working registers iterate in place; the visible results change only when an
  // operation completes, so they hold through the next operation until it ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      q_work    <= '0;
      r_work    <= '0;
      d_work    <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_SIGNED_EN
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            q_work <= a_mag;
            d_work <= b_mag;
            r_work <= '0;
            count  <= '0;
`ifdef DIV_SIGNED_EN
            q_neg  <= a_neg ^ b_neg;
            r_neg  <= a_neg;
`endif
            if (div_zero) begin
              quotient  <= {DATA_W{DIV0_QUOT_BIT}};
              remainder <= dividend;
            end
          end
        end
        S_OP: begin
          q_work <= q_shifted;
          r_work <= r_next;
          count  <= count + CNT_W'(1);
`ifndef DIV_SIGNED_EN
          if (last_step) begin
            quotient  <= q_shifted;
            remainder <= r_next;
          end
`endif
        end
`ifdef DIV_SIGNED_EN
        S_FIX: begin
          quotient  <= q_neg ? (~q_work + DATA_W'(1)) : q_work;
          remainder <= r_neg ? (~r_work + DATA_W'(1)) : r_work;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider (DATA_W = 32).
// Signed vectors are added when DIV_SIGNED_EN is defined.
module tb_restoring_divider;

  localparam int unsigned W = 32;
`ifdef DIV_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
`ifdef DIV_SIGNED_EN
  logic         div_signed = 1'b0;
`endif
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         out_valid;
  logic         stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  restoring_divider #(
    .DATA_W (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef DIV_SIGNED_EN
    .div_signed (div_signed),
`endif
    .quotient   (quotient),
    .remainder  (remainder),
    .out_valid  (out_valid),
    .stall      (stall)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
`ifdef DIV_SIGNED_EN
    div_signed = sgn;
`else
    if (sgn) $display("note: signed vector requested in unsigned build");
`endif
    #1;
    check_eq("accept_stall", W'(stall), W'(1));
  endtask

  // Waits through the accept edge, then counts negedges until out_valid.
  // With hold=1 in_valid stays high and the operands keep changing.
  task automatic wait_done(input bit hold, output int lat, output int stalls);
    lat    = 0;
    stalls = 0;
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
      if (!hold) in_valid = 1'b0;
      else begin
        dividend = dividend * 3 + 1;
        divisor  = divisor + 5;
      end
      if (!out_valid && stall) stalls++;
    end while (!out_valid && lat < 200);
    check_eq("end_stall", W'(stall), W'(0));
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input int elat);
    int lat, stalls;
    start_op(a, b, sgn);
    wait_done(1'b0, lat, stalls);
    check_eq({tag, "_lat"}, W'(lat), W'(elat));
    check_eq({tag, "_stalls"}, W'(stalls), W'(elat - 1));
    check_eq({tag, "_q"}, quotient, eq);
    check_eq({tag, "_r"}, remainder, er);
    @(negedge clk);
    check_eq({tag, "_pulse"}, W'(out_valid), W'(0));
    check_eq({tag, "_hold_q"}, quotient, eq);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, stalls, seen;

    repeat (3) @(negedge clk);
    check_eq("rst_q", quotient, '0);
    check_eq("rst_r", remainder, '0);
    check_eq("rst_valid", W'(out_valid), W'(0));
    check_eq("rst_stall", W'(stall), W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_stall", W'(stall), W'(0));

    run_check("d100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, LAT);
    repeat (3) @(negedge clk);
    check_eq("idle_hold_r", remainder, 32'd2);
    run_check("dmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, LAT);
    run_check("d5_9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, LAT);
    run_check("div0", 32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1);

    // Abort 50/3 partway through with an asynchronous reset.
    start_op(32'd50, 32'd3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_q", quotient, '0);
    check_eq("abort_r", remainder, '0);
    check_eq("abort_stall", W'(stall), W'(0));
    check_eq("abort_valid", W'(out_valid), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("abort_no_valid", W'(seen), W'(0));
    run_check("d9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, LAT);

    // in_valid held high: only the first operands count, END does not re-accept.
    start_op(32'd200, 32'd10, 1'b0);
    wait_done(1'b1, lat, stalls);
    check_eq("held_lat", W'(lat), W'(LAT));
    check_eq("held_q", quotient, 32'd20);
    check_eq("held_r", remainder, 32'd0);
    dividend = 32'd60;
    divisor  = 32'd7;
    @(negedge clk);
    check_eq("held_idle_stall", W'(stall), W'(1));
    check_eq("held_idle_valid", W'(out_valid), W'(0));
    check_eq("held_idle_q", quotient, 32'd20);
    wait_done(1'b0, lat, stalls);
    check_eq("next_lat", W'(lat), W'(LAT));
    check_eq("next_q", quotient, 32'd8);
    check_eq("next_r", remainder, 32'd4);

`ifdef DIV_SIGNED_EN
    run_check("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT);
    run_check("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, LAT);
    run_check("u_big", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, LAT);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
